// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one grant per cycle.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default build is round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_eq,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_eq,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_eq,
  output logic [CNT_W-1:0] op_count
);

  logic             w_elig0, w_elig1;
  logic             w_grant0, w_grant1;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_data, r_rsp1_data;
  logic             r_rsp0_eq, r_rsp1_eq;
  logic [CNT_W-1:0] r_op_count;

  // A full response slot may be refilled in the same cycle it is drained.
  assign w_elig0 = req0_valid & (~r_rsp0_valid | rsp0_ready);
  assign w_elig1 = req1_valid & (~r_rsp1_valid | rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant0 = ~reset & w_elig0;
  assign w_grant1 = ~reset & w_elig1 & ~w_elig0;
`else
  logic r_prio;

  assign w_grant0 = ~reset & w_elig0 & (~w_elig1 | ~r_prio);
  assign w_grant1 = ~reset & w_elig1 & (~w_elig0 | r_prio);

  // r_prio points at the port that did not win the most recent grant.
  always_ff @(posedge clk) begin
    if (reset)         r_prio <= 1'b0;
    else if (w_grant0) r_prio <= 1'b1;
    else if (w_grant1) r_prio <= 1'b0;
  end
`endif

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    alu_src_a = '0;
    alu_src_b = '0;
    alu_ctrl  = '0;
    if (w_grant0) begin
      alu_src_a = req0_a;
      alu_src_b = req0_b;
      alu_ctrl  = req0_op;
    end else if (w_grant1) begin
      alu_src_a = req1_a;
      alu_src_b = req1_b;
      alu_ctrl  = req1_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_eq    <= 1'b0;
    end else if (w_grant0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= alu_res;
      r_rsp0_eq    <= alu_eq;
    end else if (rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_eq    <= 1'b0;
    end else if (w_grant1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= alu_res;
      r_rsp1_eq    <= alu_eq;
    end else if (rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                      r_op_count <= '0;
    else if (w_grant0 | w_grant1)   r_op_count <= r_op_count + 1'b1;
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp0_eq    = r_rsp0_eq;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_data  = r_rsp1_data;
  assign rsp1_eq    = r_rsp1_eq;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus randomized run against a behavioural model,
// with a simple ALU stand-in driving alu_res/alu_eq from the arbiter's ALU outputs.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_op, req1_op;
  logic [W-1:0]  alu_src_a, alu_src_b, alu_res;
  logic [3:0]    alu_ctrl;
  logic          alu_eq;
  logic          rsp0_valid, rsp0_ready, rsp0_eq;
  logic          rsp1_valid, rsp1_ready, rsp1_eq;
  logic [W-1:0]  rsp0_data, rsp1_data;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res), .alu_eq(alu_eq),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_eq(rsp0_eq),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_eq(rsp1_eq),
    .op_count(op_count)
  );

  function automatic logic [W-1:0] aluRef(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return b << 16;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the external ALU instance.
  always_comb begin
    alu_res = aluRef(alu_src_a, alu_src_b, alu_ctrl);
    alu_eq  = (alu_src_a == alu_src_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: per-port response slot, preferred port, grant counter.
  bit           m_v[2];
  logic [W-1:0] m_d[2];
  bit           m_eq[2];
  int           m_cnt = 0;
  int           m_prio = 0;
  int           m_g = -1;
  logic [W-1:0] m_ga, m_gb;
  logic [3:0]   m_gop;

  task automatic modelPre();
    bit el0, el1;
    el0 = req0_valid && (!m_v[0] || rsp0_ready);
    el1 = req1_valid && (!m_v[1] || rsp1_ready);
    m_g = -1;
    if (!reset) begin
      if (el0 && el1) m_g = FIXED ? 0 : m_prio;
      else if (el0)   m_g = 0;
      else if (el1)   m_g = 1;
    end
    m_ga = '0; m_gb = '0; m_gop = '0;
    if (m_g == 0) begin m_ga = req0_a; m_gb = req0_b; m_gop = req0_op; end
    if (m_g == 1) begin m_ga = req1_a; m_gb = req1_b; m_gop = req1_op; end
    check("model req0_ready", req0_ready, m_g == 0);
    check("model req1_ready", req1_ready, m_g == 1);
    check("model alu_src_a", alu_src_a, m_ga);
    check("model alu_src_b", alu_src_b, m_gb);
    check("model alu_ctrl", alu_ctrl, m_gop);
  endtask

  task automatic modelUpdate();
    bit rr[2];
    rr[0] = rsp0_ready;
    rr[1] = rsp1_ready;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_d[i] = '0; m_eq[i] = 0; end
      m_cnt = 0;
      m_prio = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_g == i) begin
          m_d[i] = aluRef(m_ga, m_gb, m_gop);
          m_eq[i] = (m_ga == m_gb);
          m_v[i] = 1;
        end else if (m_v[i] && rr[i]) begin
          m_v[i] = 0;
        end
      end
      if (m_g >= 0) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_prio = 1 - m_g;
      end
    end
  endtask

  task automatic modelPost();
    check("model rsp0_valid", rsp0_valid, m_v[0]);
    check("model rsp0_data", rsp0_data, m_d[0]);
    check("model rsp0_eq", rsp0_eq, m_eq[0]);
    check("model rsp1_valid", rsp1_valid, m_v[1]);
    check("model rsp1_data", rsp1_data, m_d[1]);
    check("model rsp1_eq", rsp1_eq, m_eq[1]);
    check("model op_count", op_count, m_cnt);
  endtask

  // Inputs are already driven; compare comb outputs, cross the edge, compare registers.
  task automatic tick();
    #1 modelPre();
    @(posedge clk);
    modelUpdate();
    #1 modelPost();
  endtask

  typedef struct {
    logic rst;
    logic v0; logic [W-1:0] a0, b0; logic [3:0] op0;
    logic v1; logic [W-1:0] a1, b1; logic [3:0] op1;
    logic rr0, rr1;
    logic eR0, eR1, eV0; logic [W-1:0] eD0; logic eV1; logic [W-1:0] eD1; int eC;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic rst,
                              input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] op0,
                              input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] op1,
                              input logic rr0, input logic rr1, input logic eR0, input logic eR1,
                              input logic eV0, input logic [W-1:0] eD0, input logic eV1, input logic [W-1:0] eD1,
                              input int eC);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1; v.rr0 = rr0; v.rr1 = rr1;
    v.eR0 = eR0; v.eR1 = eR1; v.eV0 = eV0; v.eD0 = eD0; v.eV1 = eV1; v.eD1 = eD1; v.eC = eC;
    return v;
  endfunction

  task automatic buildTable();
    vec_t rstRow;
    rstRow = mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0);
    vec.push_back(rstRow);
    vec.push_back(mk(0, 1,5,7,0, 0,0,0,0, 0,0, 1,0, 1,12, 0,0, 1));
    vec.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,12, 0,0, 1));
    vec.push_back(rstRow);
`ifdef ALU_ARB_FIXED_PRIO_EN
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 1,0, 1,0, 0,0, 1));
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 1,0, 1,0, 0,0, 2));
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 1,0, 1,0, 0,0, 3));
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 1,0, 1,0, 0,0, 4));
`else
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 1,0, 1,0, 0,0, 1));
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 0,1, 0,0, 1,32'h12340000, 2));
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 1,0, 1,0, 0,32'h12340000, 3));
    vec.push_back(mk(0, 1,9,9,1, 1,0,32'h1234,4, 1,1, 0,1, 0,0, 1,32'h12340000, 4));
`endif
    vec.push_back(rstRow);
    vec.push_back(mk(0, 0,0,0,0, 1,1,2,0,  0,0, 0,1, 0,0, 1,3, 1));
    vec.push_back(mk(0, 1,2,3,2, 1,10,4,1, 1,0, 1,0, 1,2, 1,3, 2));
    vec.push_back(mk(0, 1,2,3,2, 1,10,4,1, 1,0, 1,0, 1,2, 1,3, 3));
    vec.push_back(mk(0, 0,2,3,2, 1,10,4,1, 1,1, 0,1, 0,2, 1,6, 4));
    vec.push_back(mk(0, 1,1,1,0, 0,0,0,0,  0,0, 1,0, 1,2, 1,6, 5));
    vec.push_back(mk(1, 1,7,7,0, 0,0,0,0,  0,0, 0,0, 0,0, 0,0, 0));
    vec.push_back(mk(0, 1,32'hF0,32'h0F,3, 1,1,1,0, 1,1, 1,0, 1,32'hFF, 0,0, 1));
    vec.push_back(mk(0, 0,0,0,0, 0,0,0,0,  0,0, 0,0, 1,32'hFF, 0,0, 1));
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    rsp0_ready = v.rr0; rsp1_ready = v.rr1;
  endtask

  task automatic checkOutput(input vec_t v, input bit afterEdge, input int idx);
    if (!afterEdge) begin
      check($sformatf("row%0d req0_ready", idx), req0_ready, v.eR0);
      check($sformatf("row%0d req1_ready", idx), req1_ready, v.eR1);
    end else begin
      check($sformatf("row%0d rsp0_valid", idx), rsp0_valid, v.eV0);
      check($sformatf("row%0d rsp0_data", idx), rsp0_data, v.eD0);
      check($sformatf("row%0d rsp1_valid", idx), rsp1_valid, v.eV1);
      check($sformatf("row%0d rsp1_data", idx), rsp1_data, v.eD1);
      check($sformatf("row%0d op_count", idx), op_count, v.eC);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);

    buildTable();
    foreach (vec[i]) begin
      applyStimulus(vec[i]);
      #1 checkOutput(vec[i], 1'b0, i);
      tick();
      checkOutput(vec[i], 1'b1, i);
      @(negedge clk);
    end

    // Counter wrap: 17 back-to-back grants on port 0 with a 4-bit counter.
    applyStimulus(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0));
    tick();
    @(negedge clk);
    for (int k = 1; k <= 17; k++) begin
      v = mk(0, 1,k,1,0, 0,0,0,0, 1,0, 0,0, 0,0, 0,0, 0);
      applyStimulus(v);
      tick();
      if (k == 15) check("wrap count after 15", op_count, 15);
      if (k == 16) check("wrap count after 16", op_count, 0);
      if (k == 17) check("wrap count after 17", op_count, 1);
      @(negedge clk);
    end

    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_a     = $urandom;
      req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req0_op    = 4'($urandom_range(0, 7));
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_a     = $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req1_op    = 4'($urandom_range(0, 7));
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      tick();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the single combinational ALU between two requesters, for example the main datapath and a multiply/divide or debug sequencer. Each cycle it grants at most one request, drives the chosen operands and opcode onto the ALU, and captures the result into that port's response register. Each response register holds its result until the requester accepts it. The arbiter sits between the requesters and the ALU instance, and all ALU inputs are driven from this block.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; it must match the ALU datapath.
- `CNT_W`, 16, width of the completed-operation counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request pending on port 0 / port 1.
- `req0_ready`, `req1_ready`  out  1  grant; the request is consumed this cycle when valid and ready are both high.
- `req0_a`, `req1_a`  in  WIDTH  operand A per port.
- `req0_b`, `req1_b`  in  WIDTH  operand B per port.
- `req0_op`, `req1_op`  in  4  opcode per port: 0 add, 1 sub, 2 and, 3 or, 4 lui.
- `alu_src_a`  out  WIDTH  to ALU SrcA.
- `alu_src_b`  out  WIDTH  to ALU SrcB.
- `alu_ctrl`  out  4  to ALU ALUControl.
- `alu_res`  in  WIDTH  from ALU Res.
- `alu_eq`  in  1  from ALU equality flag (SrcA==SrcB).
- `rsp0_valid`, `rsp1_valid`  out  1  response register full.
- `rsp0_ready`, `rsp1_ready`  in  1  requester accepts the response.
- `rsp0_data`, `rsp1_data`  out  WIDTH  captured result.
- `rsp0_eq`, `rsp1_eq`  out  1  captured equality flag.
- `op_count`  out  CNT_W  number of granted operations; wraps modulo 2^CNT_W.

## Operation
**Eligibility**
- Port i is eligible when `reqi_valid` = 1 AND (`rspi_valid` = 0 OR `rspi_ready` = 1).
- The second clause lets a full response slot be drained and refilled in the same cycle.

**Arbitration** (combinational, round-robin)
- Register `prio` names the preferred port; its reset value is 0.
- If only one port is eligible, that port is granted.
- If both ports are eligible, port `prio` is granted.
- After any grant, `prio` becomes the other port than the one granted.
- `prio` is unchanged in cycles with no grant.
- At most one `reqi_ready` is high per cycle.
- `reqi_ready` depends only on current inputs and state: it is not registered, and it is not gated on handshake completion.

**ALU drive**
- When port g is granted, `alu_src_a`/`alu_src_b`/`alu_ctrl` = `reqg_a`/`reqg_b`/`reqg_op`.
- With no grant, all three ALU outputs are 0.
- Opcodes are passed to the ALU unmodified. Undefined codes (5–15) yield whatever the ALU produces, which is 0 with eq computed normally.

**Response capture** (on the rising edge, port g granted)
- `rspg_data` <= `alu_res`.
- `rspg_eq` <= `alu_eq`.
- `rspg_valid` <= 1.
- `op_count` <= `op_count` + 1.

**Response drain**
- Port i not granted and `rspi_valid` & `rspi_ready`: `rspi_valid` <= 0; data and eq are held.
- Grant and drain on the same port in the same cycle: `rspi_valid` stays 1 with the new data.

**Requester rules**
- Requesters hold a, b and op stable while valid = 1 and ready = 0.
- Dropping valid before the grant is permitted and withdraws the request.

## Timing
- Request-to-response latency: the grant happens in cycle n, and `rspg_valid` is high with the result from cycle n+1.
- Peak throughput: one operation per cycle in total. With both ports continuously requesting and draining, ports alternate 0,1,0,1…
- A port whose response is full and not being drained stalls (ready = 0). The other port may still be granted.

**Reset** (synchronous, takes effect at the next edge, overrides every other action in that cycle)
- `rsp*_valid` = 0.
- `rsp*_data` = 0.
- `rsp*_eq` = 0.
- `prio` = 0.
- `op_count` = 0.

**During reset cycles**
- `req*_ready` is forced to 0.
- ALU outputs are forced to 0.
- An operation granted in the cycle reset asserts is discarded.

**Counter wrap:** `op_count` at 2^CNT_W−1 plus one grant becomes 0.

## Configuration
Macro `ALU_ARB_FIXED_PRIO_EN` selects the arbitration policy.
- **Defined:** fixed priority. Port 0 always wins when both ports are eligible, and `prio` is not implemented.
- **Undefined (default):** round-robin, as in Operation.
- All other behaviour is identical in both builds.

## Test plan
1. **Single add:** port 0 requests a=5, b=7, op=0 -> `req0_ready` = 1 the same cycle; next cycle `rsp0_valid` = 1, `rsp0_data` = 12, `rsp0_eq` = 0, `op_count` = 1.
2. **Round-robin contention:** both ports request continuously from reset with `rsp*_ready` = 1; port 0 sub 9−9 and port 1 lui b=0x1234 -> grants alternate 0,1,0,1; `rsp0_data` = 0 with `rsp0_eq` = 1; `rsp1_data` = 0x12340000. With `ALU_ARB_FIXED_PRIO_EN` defined, port 0 is granted every cycle.
3. **Backpressure:** port 1 response full with `rsp1_ready` = 0 and `req1_valid` = 1 -> `req1_ready` stays 0 and port 0 requests are still granted each cycle. Raising `rsp1_ready` -> port 1 is granted that same cycle, and `rsp1_valid` remains 1 with the new data.
4. **Reset mid-operation:** both responses valid, `op_count` = 3, reset asserted in the same cycle as a port 0 grant -> after the edge all `rsp*_valid` = 0, data = 0, `op_count` = 0, and the next contended grant goes to port 0.
5. **Counter wrap:** `CNT_W` = 4, perform 17 grants -> `op_count` reads 15 after the 15th grant, 0 after the 16th, and 1 after the 17th.
6. **Idle drive:** no requests -> `alu_src_a` = `alu_src_b` = 0, `alu_ctrl` = 0, and `prio` and `op_count` are unchanged.
